// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits (MSB first), optional parity, stop bit.
// Bit timing comes from a free-running tick counter used as a clock enable on clk.
module serial_frame_rx #(
  parameter int unsigned DATA_W     = 5,
  parameter int unsigned DIV        = 500,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BitW = $clog2(DATA_W);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e              state_q, state_d;
  logic [1:0]          sync_q;
  logic [CntW-1:0]     cnt_q;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   sr_q, sr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                acc_q, acc_d;
  logic                perr_flag_q, perr_flag_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
  logic                perr_q, perr_d;
  logic                tick;
  logic                sample;

  assign tick   = (cnt_q == CntW'(DIV - 1));
  assign sample = sync_q[1];

  // Counter is never re-aligned to the start bit; each bit window holds exactly one tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], data_in};
      cnt_q  <= tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      dout_q      <= '0;
      acc_q       <= 1'b0;
      perr_flag_q <= 1'b0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      dout_q      <= dout_d;
      acc_q       <= acc_d;
      perr_flag_q <= perr_flag_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      perr_q      <= perr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    dout_d      = dout_q;
    acc_d       = acc_q;
    perr_flag_d = perr_flag_q;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;
    perr_d      = 1'b0;
    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (!sample) begin
            state_d     = StData;
            bit_cnt_d   = '0;
            sr_d        = '0;
            acc_d       = 1'(PARITY_ODD);
            perr_flag_d = 1'b0;
          end
        end
        StData: begin
          sr_d      = {sr_q[DATA_W-2:0], sample};
          acc_d     = acc_q ^ sample;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BitW'(DATA_W - 1)) begin
            state_d = (PARITY_EN != 0) ? StParity : StStop;
          end
        end
        StParity: begin
          perr_flag_d = acc_q ^ sample;
          state_d     = StStop;
        end
        StStop: begin
          ferr_d = ~sample;
          perr_d = perr_flag_q;
          if (sample && !perr_flag_q) begin
            dout_d  = sr_q;
            valid_d = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign busy       = (state_q != StIdle);

endmodule
